// File: rtl/sti_rx_if.sv
// STI receive-side bundle: word format, serial input and parallel output.
interface sti_rx_if #(
  parameter int CNT_W = 8
);
  logic             cfg_load;
  logic [1:0]       cfg_length;
  logic             cfg_msb;
  logic             si_data;
  logic             si_valid;
  logic [31:0]      po_data;
  logic             po_valid;
  logic [1:0]       po_width;
  logic             po_err;
  logic             busy;
  logic [CNT_W-1:0] word_count;

  modport master (
    output cfg_load, cfg_length, cfg_msb,
    output si_data, si_valid,
    input  po_data, po_valid, po_width,
    input  po_err, busy, word_count
  );

  modport slave (
    input  cfg_load, cfg_length, cfg_msb,
    input  si_data, si_valid,
    output po_data, po_valid, po_width,
    output po_err, busy, word_count
  );
endinterface

// File: rtl/sti_rx.sv
// STI serial-to-parallel receiver: rebuilds 8..32-bit words
// from a latched format, flags words cut short by si_valid.
module sti_rx #(
  parameter int CNT_W = 8
) (
  input logic   clk,
  input logic   reset,
  sti_rx_if.slave bus
);

  typedef enum logic {IDLE, RECV} state_t;

  state_t           state, state_n;
  logic [1:0]       len_q, len_n;
  logic             msb_q, msb_n;
  logic [5:0]       cnt, cnt_n;
  logic [5:0]       last, pos;
  logic [31:0]      sh, sh_n;
  logic [31:0]      data_n;
  logic             valid_n, err_n;
  logic [1:0]       width_n;
  logic [CNT_W-1:0] wc_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      len_q          <= '0;
      msb_q          <= 1'b0;
      cnt            <= '0;
      sh             <= '0;
      bus.po_data    <= '0;
      bus.po_valid   <= 1'b0;
      bus.po_width   <= '0;
      bus.po_err     <= 1'b0;
      bus.busy       <= 1'b0;
      bus.word_count <= '0;
    end else begin
      state          <= state_n;
      len_q          <= len_n;
      msb_q          <= msb_n;
      cnt            <= cnt_n;
      sh             <= sh_n;
      bus.po_data    <= data_n;
      bus.po_valid   <= valid_n;
      bus.po_width   <= width_n;
      bus.po_err     <= err_n;
      bus.busy       <= (state_n == RECV);
      bus.word_count <= wc_n;
    end
  end

  // last = W-1 = 8*len + 7
  assign last = {1'b0, len_q, 3'b111};
  assign pos  = msb_q ? (last - cnt) : cnt;

  always_comb begin
    state_n = state;
    len_n   = len_q;
    msb_n   = msb_q;
    cnt_n   = cnt;
    sh_n    = sh;
    data_n  = bus.po_data;
    width_n = bus.po_width;
    valid_n = 1'b0;
    err_n   = 1'b0;
    wc_n    = bus.word_count;
    unique case (state)
      IDLE: begin
        if (bus.cfg_load) begin
          len_n   = bus.cfg_length;
          msb_n   = bus.cfg_msb;
          sh_n    = '0;
          cnt_n   = '0;
          state_n = RECV;
        end
      end
      RECV: begin
        if (bus.si_valid) begin
          sh_n[pos] = bus.si_data;
          cnt_n     = cnt + 6'd1;
          if (cnt == last) begin
            data_n  = sh_n;
            width_n = len_q;
            valid_n = 1'b1;
            wc_n    = bus.word_count + CNT_W'(1);
            state_n = IDLE;
          end
        end else if (cnt != 6'd0) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sti_rx.sv
// Directed bench for sti_rx: formats, abort, reset,
// ignored reload and 256 back-to-back words.
module tb_sti_rx;

  logic clk = 1'b0;
  logic reset;
  int   passed = 0;
  int   total  = 0;

  sti_rx_if #(.CNT_W(8)) bus ();

  sti_rx #(.CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic load(input logic [1:0] len, input logic msb);
    bus.cfg_load   = 1'b1;
    bus.cfg_length = len;
    bus.cfg_msb    = msb;
    @(posedge clk); #1;
    bus.cfg_load   = 1'b0;
  endtask

  task automatic bits(input logic [31:0] val, input int w,
                      input logic msb, input int n);
    for (int i = 0; i < n; i++) begin
      bus.si_valid = 1'b1;
      bus.si_data  = msb ? val[w-1-i] : val[i];
      @(posedge clk); #1;
    end
    bus.si_valid = 1'b0;
    bus.si_data  = 1'b0;
  endtask

  task automatic send(input logic [31:0] val,
                      input logic [1:0] len, input logic msb);
    int w;
    w = 8 * (int'(len) + 1);
    load(len, msb);
    bits(val, w, msb, w);
  endtask

  task automatic word(input string tag, input logic [31:0] val,
                      input logic [1:0] len, input logic msb);
    send(val, len, msb);
    chk({tag, "_valid"}, 32'(bus.po_valid), 32'd1);
    chk({tag, "_data"},  bus.po_data, val);
    chk({tag, "_width"}, 32'(bus.po_width), 32'(len));
    chk({tag, "_err"},   32'(bus.po_err), 32'd0);
    chk({tag, "_busy"},  32'(bus.busy), 32'd0);
  endtask

  initial begin
    int good;
    reset          = 1'b1;
    bus.cfg_load   = 1'b0;
    bus.cfg_length = 2'b00;
    bus.cfg_msb    = 1'b0;
    bus.si_data    = 1'b0;
    bus.si_valid   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data",  bus.po_data, 32'h0);
    chk("rst_valid", 32'(bus.po_valid), 32'd0);
    chk("rst_width", 32'(bus.po_width), 32'd0);
    chk("rst_err",   32'(bus.po_err), 32'd0);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_wc",    32'(bus.word_count), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // si_valid in IDLE must not start a word
    bus.si_valid = 1'b1;
    bus.si_data  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.si_valid = 1'b0;
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_wc",   32'(bus.word_count), 32'd0);

    word("w8msb", 32'h000000A5, 2'b00, 1'b1);
    chk("w8msb_wc", 32'(bus.word_count), 32'd1);
    @(posedge clk); #1;
    chk("w8msb_pulse", 32'(bus.po_valid), 32'd0);
    chk("w8msb_hold",  bus.po_data, 32'h000000A5);

    word("w16lsb", 32'h00001234, 2'b01, 1'b0);
    word("w32msb", 32'hDEADBEEF, 2'b11, 1'b1);
    word("w24lsb", 32'h00ABCDEF, 2'b10, 1'b0);
    chk("w24_wc", 32'(bus.word_count), 32'd4);

    // abort after 5 of 8 bits; wait in RECV before first bit first
    load(2'b00, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("wait_busy", 32'(bus.busy), 32'd1);
    bits(32'h3C, 8, 1'b0, 5);
    chk("abort_busy_pre", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    chk("abort_err",   32'(bus.po_err), 32'd1);
    chk("abort_valid", 32'(bus.po_valid), 32'd0);
    chk("abort_data",  bus.po_data, 32'h00ABCDEF);
    chk("abort_wc",    32'(bus.word_count), 32'd4);
    chk("abort_busy",  32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    chk("abort_pulse", 32'(bus.po_err), 32'd0);
    word("after_abort", 32'h0000003C, 2'b00, 1'b0);
    chk("after_abort_wc", 32'(bus.word_count), 32'd5);

    // cfg_load during RECV carries a different format; must be ignored
    load(2'b01, 1'b0);
    for (int i = 0; i < 16; i++) begin
      logic [15:0] v;
      v = 16'h5AA5;
      bus.cfg_load   = (i == 3);
      bus.cfg_length = 2'b00;
      bus.cfg_msb    = 1'b1;
      bus.si_valid   = 1'b1;
      bus.si_data    = v[i];
      @(posedge clk); #1;
    end
    bus.cfg_load = 1'b0;
    bus.si_valid = 1'b0;
    chk("ign_valid", 32'(bus.po_valid), 32'd1);
    chk("ign_data",  bus.po_data, 32'h00005AA5);
    chk("ign_width", 32'(bus.po_width), 32'd1);

    // reset after 10 of 16 bits
    load(2'b01, 1'b1);
    bits(32'h0000F00F, 16, 1'b1, 10);
    reset = 1'b1;
    #1;
    chk("mrst_data",  bus.po_data, 32'h0);
    chk("mrst_width", 32'(bus.po_width), 32'd0);
    chk("mrst_busy",  32'(bus.busy), 32'd0);
    chk("mrst_wc",    32'(bus.word_count), 32'd0);
    chk("mrst_err",   32'(bus.po_err), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("mrst_err2",  32'(bus.po_err), 32'd0);
    chk("mrst_busy2", 32'(bus.busy), 32'd0);
    word("after_rst", 32'h00C0FFEE, 2'b10, 1'b1);
    chk("after_rst_wc", 32'(bus.word_count), 32'd1);

    // 256 back-to-back bytes from a clean count; cfg_load on po_valid cycle
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    good = 0;
    for (int k = 0; k < 256; k++) begin
      logic [31:0] exp;
      exp = 32'((k * 37 + 11) & 255);
      send(exp, 2'b00, k[0]);
      if (bus.po_valid === 1'b1 && bus.po_data === exp &&
          bus.po_err === 1'b0)
        good++;
    end
    chk("b2b_words", 32'(good), 32'd256);
    chk("b2b_wc",    32'(bus.word_count), 32'd0);
    @(posedge clk); #1;
    chk("b2b_end_valid", 32'(bus.po_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sti_rx.md
Name: sti_rx

Overview:
Serial-to-parallel receiver for the single-bit STI serial stream (data bit plus valid). It rebuilds 8/16/24/32-bit words from a per-word format supplied at load time (width and bit order), presents each word right-justified on a 32-bit bus with a one-cycle valid pulse, and flags truncated words. It is the receive-end counterpart used by loopback benches and downstream consumers of the serial output.

Parameters:
CNT_W, 8, width of the received-word counter (wraps modulo 2^CNT_W)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
cfg_load  input  1  1-cycle strobe: latch format for next word (accepted in IDLE only)
cfg_length  input  2  word width: 00=8, 01=16, 10=24, 11=32 bits
cfg_msb  input  1  1 = first serial bit is word MSB; 0 = first bit is LSB
si_data  input  1  serial data bit
si_valid  input  1  si_data valid this cycle
po_data  output  32  received word, right-justified, upper bits zero
po_valid  output  1  1-cycle pulse: po_data holds a complete word
po_width  output  2  cfg_length of the word on po_data
po_err  output  1  1-cycle pulse: word aborted (si_valid dropped mid-word)
busy  output  1  high while in RECV
word_count  output  CNT_W  count of completed words

Behaviour:
- Reset (async, immediate): state IDLE; po_data=0, po_valid=0, po_width=0, po_err=0, busy=0, word_count=0; bit counter, shift register, latched format cleared. Reset mid-word discards the partial word, with no po_err.
- W = 8*(cfg_length+1); bit counter 6 bits, 0..W-1.
- IDLE: cfg_load=1 latches cfg_length/cfg_msb, clears shift register and bit counter, and moves to RECV next cycle. si_valid in IDLE is ignored.
- RECV, before the first bit: wait indefinitely while si_valid=0 (no timeout). cfg_load in RECV is ignored.
- RECV, on each edge with si_valid=1: write si_data into shift-register bit position (cfg_msb ? W-1-cnt : cnt), then increment cnt.
- Word completion: on the edge sampling bit W-1:
  - next cycle po_data = assembled word (bits 31..W zero), po_width = latched length, po_valid=1 for exactly 1 cycle;
  - word_count increments, wrapping 2^CNT_W-1 -> 0;
  - state returns to IDLE.
  - Latency: last bit edge -> po_valid is 1 cycle.
- Abort: in RECV with cnt>=1 and si_valid=0 on a sampling edge, the next cycle has po_err=1 for 1 cycle and state IDLE. po_data keeps its previous value and word_count is unchanged.
- po_data and po_width hold their value until the next completed word.
- Back-to-back words: the po_valid cycle is in IDLE, so cfg_load asserted in that cycle is accepted. With this, word N+1 bits may start 1 cycle after cfg_load, with no lost words.
- busy = (state==RECV), registered with the state.
- po_valid and po_err are never high together.

Test Plan:
- cfg_load len=00 msb=1, then bits 1,0,1,0,0,1,0,1 with si_valid=1 -> po_valid 1 cycle after 8th bit, po_data=0x000000A5, po_width=00, word_count=1.
- len=01 msb=0, stream 0x1234 LSB-first (bits 0,0,1,0,1,1,0,0,0,1,0,0,1,0,0,0) -> po_data=0x00001234.
- len=11 msb=1, stream 0xDEADBEEF; len=10 msb=0, stream 0xABCDEF LSB-first -> po_data=0xDEADBEEF, then 0x00ABCDEF; po_width 11 then 10.
- len=00, 5 bits then si_valid=0 -> po_err=1 one cycle, no po_valid, po_data retains prior value, word_count unchanged; next load/word received correctly.
- Reset asserted after 10 of 16 bits -> all outputs 0 immediately, no po_err; next full word decodes correctly. Also cfg_load during RECV is ignored (format unchanged).
- 256 back-to-back 8-bit words with cfg_load on each po_valid cycle -> 256 po_valid pulses, none lost, word_count wraps to 0.
